// File: rtl/exec_unit_mc.sv
// Execute stage: ALU, NZCV flag register, branch-condition evaluation and an iterative multiplier.
// Define EXEC_MUL_RADIX4_EN to have the multiplier retire 2 bits per cycle instead of 1.
module exec_unit_mc #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic              set_flags,
    input  logic              use_imm,
    input  logic [REG_AW-1:0] dest_reg,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [IMM_W-1:0]  imm,
    input  logic              flush,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              br_valid,
    output logic              br_taken,
    output logic [IMM_W-1:0]  br_offset,
    output logic [3:0]        flags
);

`ifdef EXEC_MUL_RADIX4_EN
    localparam int STEP_BITS = 2;
`else
    localparam int STEP_BITS = 1;
`endif
    localparam int NUM_STEPS = DATA_W / STEP_BITS;
    localparam int CNT_W     = $clog2(NUM_STEPS) + 1;
    localparam int MSB       = DATA_W - 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MOV = 4'd2;
    localparam logic [3:0] OP_CLR = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_BEQ = 4'd5;
    localparam logic [3:0] OP_BNE = 4'd6;
    localparam logic [3:0] OP_BMI = 4'd7;
    localparam logic [3:0] OP_BPL = 4'd8;

    logic [0:0]        stateReg;
    logic [DATA_W-1:0] immExt, opB;
    logic [DATA_W:0]   addRes, subRes;
    logic [3:0]        addFlags, subFlags;
    logic              accept, brCond, lastStep;

    logic [DATA_W-1:0] mcandReg, mplierReg, accReg, accSum;
    logic [CNT_W-1:0]  stepCntReg;
    logic [REG_AW-1:0] mulDestReg;
    logic              mulSetFlagsReg;
    logic [DATA_W-1:0] pp [STEP_BITS];

    logic              wbValidReg, brValidReg, brTakenReg;
    logic [REG_AW-1:0] wbRegReg;
    logic [DATA_W-1:0] wbDataReg;
    logic [IMM_W-1:0]  brOffsetReg;
    logic [3:0]        flagsReg;

    assign immExt   = DATA_W'($signed(imm));
    assign opB      = use_imm ? immExt : op_b;
    assign in_ready = (stateReg == ST_IDLE);
    assign accept   = in_valid & in_ready & ~flush;
    assign lastStep = (stepCntReg == CNT_W'(NUM_STEPS - 1));

    assign addRes   = {1'b0, op_a} + {1'b0, opB};
    assign subRes   = {1'b0, op_a} - {1'b0, opB};
    assign addFlags = {addRes[MSB], addRes[MSB:0] == '0, addRes[DATA_W],
                       (op_a[MSB] == opB[MSB]) && (addRes[MSB] != op_a[MSB])};
    // Carry on subtract is the inverted borrow out of the extra top bit.
    assign subFlags = {subRes[MSB], subRes[MSB:0] == '0, ~subRes[DATA_W],
                       (op_a[MSB] != opB[MSB]) && (subRes[MSB] != op_a[MSB])};

    always_comb begin
        brCond = 1'b0;
        case (op)
            OP_BEQ:  brCond = flagsReg[2];
            OP_BNE:  brCond = ~flagsReg[2];
            OP_BMI:  brCond = flagsReg[3];
            OP_BPL:  brCond = ~flagsReg[3];
            default: brCond = 1'b0;
        endcase
    end

    // One partial product per multiplier bit retired this step.
    for (genvar gi = 0; gi < STEP_BITS; gi++) begin : g_pp
        assign pp[gi] = mplierReg[gi] ? (mcandReg << gi) : '0;
    end

    always_comb begin
        accSum = accReg;
        for (int i = 0; i < STEP_BITS; i++) begin
            accSum = accSum + pp[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg       <= ST_IDLE;
            mcandReg       <= '0;
            mplierReg      <= '0;
            accReg         <= '0;
            stepCntReg     <= '0;
            mulDestReg     <= '0;
            mulSetFlagsReg <= 1'b0;
            wbValidReg     <= 1'b0;
            wbRegReg       <= '0;
            wbDataReg      <= '0;
            brValidReg     <= 1'b0;
            brTakenReg     <= 1'b0;
            brOffsetReg    <= '0;
            flagsReg       <= 4'b0000;
        end else begin
            wbValidReg <= 1'b0;
            brValidReg <= 1'b0;
            case (stateReg)
                ST_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_ADD, OP_SUB, OP_MOV, OP_CLR: begin
                                wbValidReg <= 1'b1;
                                wbRegReg   <= dest_reg;
                                case (op)
                                    OP_ADD:  wbDataReg <= addRes[MSB:0];
                                    OP_SUB:  wbDataReg <= subRes[MSB:0];
                                    OP_MOV:  wbDataReg <= immExt;
                                    default: wbDataReg <= '0;
                                endcase
                                if (set_flags && op == OP_ADD) flagsReg <= addFlags;
                                if (set_flags && op == OP_SUB) flagsReg <= subFlags;
                            end
                            OP_MUL: begin
                                stateReg       <= ST_MUL;
                                mcandReg       <= op_a;
                                mplierReg      <= opB;
                                accReg         <= '0;
                                stepCntReg     <= '0;
                                mulDestReg     <= dest_reg;
                                mulSetFlagsReg <= set_flags;
                            end
                            OP_BEQ, OP_BNE, OP_BMI, OP_BPL: begin
                                brValidReg  <= 1'b1;
                                brTakenReg  <= brCond;
                                brOffsetReg <= imm;
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    // Flush wins over the final step: the product is discarded untouched.
                    if (flush) begin
                        stateReg <= ST_IDLE;
                    end else begin
                        accReg     <= accSum;
                        mcandReg   <= mcandReg << STEP_BITS;
                        mplierReg  <= mplierReg >> STEP_BITS;
                        stepCntReg <= stepCntReg + 1'b1;
                        if (lastStep) begin
                            stateReg   <= ST_IDLE;
                            wbValidReg <= 1'b1;
                            wbRegReg   <= mulDestReg;
                            wbDataReg  <= accSum;
                            if (mulSetFlagsReg) flagsReg[3:2] <= {accSum[MSB], accSum == '0};
                        end
                    end
                end
            endcase
        end
    end

    assign wb_valid  = wbValidReg;
    assign wb_reg    = wbRegReg;
    assign wb_data   = wbDataReg;
    assign br_valid  = brValidReg;
    assign br_taken  = brTakenReg;
    assign br_offset = brOffsetReg;
    assign flags     = flagsReg;

endmodule

// File: tb/tb_exec_unit_mc.sv
// Scoreboard bench for exec_unit_mc: stimulus pushes expected results, a negedge monitor pops and checks.
module tb_exec_unit_mc;

`ifdef EXEC_MUL_RADIX4_EN
    localparam int MUL_STEPS = 16;
`else
    localparam int MUL_STEPS = 32;
`endif
    localparam int MUL_LAT = MUL_STEPS + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic        set_flags = 1'b0;
    logic        use_imm = 1'b0;
    logic [3:0]  dest_reg = 4'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [15:0] imm = 16'd0;
    logic        flush = 1'b0;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic [31:0] wb_data;
    logic        br_valid;
    logic        br_taken;
    logic [15:0] br_offset;
    logic [3:0]  flags;

    exec_unit_mc #(.DATA_W(32), .IMM_W(16), .REG_AW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .set_flags(set_flags), .use_imm(use_imm), .dest_reg(dest_reg), .op_a(op_a),
        .op_b(op_b), .imm(imm), .flush(flush), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .wb_data(wb_data), .br_valid(br_valid), .br_taken(br_taken), .br_offset(br_offset),
        .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          isBr;
        logic [3:0]  rg;
        logic [31:0] data;
        bit          taken;
        logic [15:0] off;
        int          cyc;
    } exp_t;

    exp_t expQ[$];
    int   posCnt = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) posCnt <= posCnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, req);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation, on time.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (wb_valid === 1'b1 || br_valid === 1'b1)) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got wb_valid=%0b br_valid=%0b want none", wb_valid, br_valid);
            end else begin
                e = expQ.pop_front();
                check("out_kind", {63'd0, br_valid}, {63'd0, e.isBr});
                check("out_cycle", 64'(posCnt), 64'(e.cyc));
                if (e.isBr) begin
                    $display("branch taken=%0b offset=0x%0h cyc=%0d", br_taken, br_offset, posCnt);
                    check("br_taken", {63'd0, br_taken}, {63'd0, e.taken});
                    check("br_offset", {48'd0, br_offset}, {48'd0, e.off});
                end else begin
                    $display("writeback reg=%0d data=0x%0h cyc=%0d", wb_reg, wb_data, posCnt);
                    check("wb_reg", {60'd0, wb_reg}, {60'd0, e.rg});
                    check("wb_data", {32'd0, wb_data}, {32'd0, e.data});
                end
            end
        end
    end

    // Call at a negedge; presents one instruction for one edge and returns at the next negedge.
    task automatic issue(input logic [3:0] o, input bit sf, input bit ui, input logic [3:0] d,
                         input logic [31:0] a, input logic [31:0] b, input logic [15:0] im,
                         input bit expOut, input logic [31:0] ed, input bit et);
        exp_t e;
        in_valid = 1'b1; op = o; set_flags = sf; use_imm = ui; dest_reg = d;
        op_a = a; op_b = b; imm = im;
        if (expOut) begin
            e.isBr  = (o >= 4'd5 && o <= 4'd8);
            e.rg    = d;
            e.data  = ed;
            e.taken = et;
            e.off   = im;
            e.cyc   = posCnt + 1 + ((o == 4'd4) ? MUL_LAT : 1) - 1;
            expQ.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitReady(input int want);
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(n), 64'(want));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("rst_br_valid", {63'd0, br_valid}, 64'd0);
        check("rst_wb_data", {32'd0, wb_data}, 64'd0);
        check("rst_flags", {60'd0, flags}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {63'd0, in_ready}, 64'd1);

        issue(4'd0, 1, 0, 4'd3, 32'h7FFF_FFFF, 32'd1, 16'd0, 1, 32'h8000_0000, 0);
        check("flags_add_ovf", {60'd0, flags}, 64'b1001);
        issue(4'd1, 1, 1, 4'd4, 32'd5, 32'd99, 16'd5, 1, 32'd0, 0);
        check("flags_sub_zero", {60'd0, flags}, 64'b0110);
        issue(4'd5, 0, 0, 4'd0, 32'd0, 32'd0, 16'h0010, 1, 32'd0, 1);
        issue(4'd0, 0, 0, 4'd1, 32'hFFFF_FFFF, 32'd2, 16'd0, 1, 32'd1, 0);
        check("flags_noset", {60'd0, flags}, 64'b0110);
        issue(4'd1, 1, 0, 4'd2, 32'd3, 32'd5, 16'd0, 1, 32'hFFFF_FFFE, 0);
        check("flags_sub_borrow", {60'd0, flags}, 64'b1000);
        issue(4'd1, 1, 0, 4'd2, 32'h8000_0000, 32'd1, 16'd0, 1, 32'h7FFF_FFFF, 0);
        check("flags_sub_ovf", {60'd0, flags}, 64'b0011);

        issue(4'd4, 1, 0, 4'd6, 32'hFFFF_FFFF, 32'd3, 16'd0, 1, 32'hFFFF_FFFD, 0);
        check("flags_mul_pending", {60'd0, flags}, 64'b0011);
        waitReady(MUL_STEPS);
        check("flags_mul", {60'd0, flags}, 64'b1011);

        issue(4'd4, 1, 0, 4'd6, 32'd7, 32'd6, 16'd0, 0, 32'd0, 0);
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("ready_after_flush", {63'd0, in_ready}, 64'd1);
        check("flags_after_flush", {60'd0, flags}, 64'b1011);

        issue(4'd0, 1, 0, 4'd1, 32'd1, 32'd1, 16'd0, 1, 32'd2, 0);
        check("flags_clear", {60'd0, flags}, 64'b0000);
        issue(4'd2, 1, 0, 4'd7, 32'd0, 32'd0, 16'h8000, 1, 32'hFFFF_8000, 0);
        check("flags_mov", {60'd0, flags}, 64'b0000);
        issue(4'd7, 0, 0, 4'd0, 32'd0, 32'd0, 16'h0004, 1, 32'd0, 0);
        issue(4'd8, 0, 0, 4'd0, 32'd0, 32'd0, 16'hFFF0, 1, 32'd0, 1);
        issue(4'd6, 0, 0, 4'd0, 32'd0, 32'd0, 16'h0022, 1, 32'd0, 1);
        issue(4'd5, 0, 0, 4'd0, 32'd0, 32'd0, 16'h0033, 1, 32'd0, 0);
        issue(4'd3, 1, 0, 4'd9, 32'd123, 32'd0, 16'd0, 1, 32'd0, 0);
        issue(4'd15, 1, 0, 4'd9, 32'd1, 32'd1, 16'd0, 0, 32'd0, 0);
        flush = 1'b1;
        issue(4'd0, 1, 0, 4'd9, 32'd1, 32'd1, 16'd0, 0, 32'd0, 0);
        flush = 1'b0;
        check("flags_nop_flush", {60'd0, flags}, 64'b0000);

        issue(4'd4, 0, 0, 4'd2, 32'd9, 32'd9, 16'd0, 1, 32'd81, 0);
        waitReady(MUL_STEPS);
        issue(4'd4, 1, 1, 4'd5, 32'h0000_1234, 32'd0, 16'hFFFF, 1, 32'hFFFF_EDCC, 0);
        waitReady(MUL_STEPS);
        check("flags_mul_imm", {60'd0, flags}, 64'b1000);
        issue(4'd7, 0, 0, 4'd0, 32'd0, 32'd0, 16'hABCD, 1, 32'd0, 1);

        issue(4'd4, 1, 0, 4'd8, 32'd7, 32'd6, 16'd0, 0, 32'd0, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_wb_data", {32'd0, wb_data}, 64'd0);
        check("midrst_wb_reg", {60'd0, wb_reg}, 64'd0);
        check("midrst_flags", {60'd0, flags}, 64'd0);
        check("midrst_br_taken", {63'd0, br_taken}, 64'd0);
        check("midrst_br_offset", {48'd0, br_offset}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_midrst", {63'd0, in_ready}, 64'd1);
        issue(4'd0, 1, 0, 4'd1, 32'd2, 32'd3, 16'd0, 1, 32'd5, 0);
        check("flags_after_midrst", {60'd0, flags}, 64'b0000);

        begin
            int n = 0;
            while (expQ.size() != 0 && n < 200) begin
                n++;
                @(negedge clk);
            end
        end
        check("pending_at_end", 64'(expQ.size()), 64'd0);
        repeat (MUL_LAT + 2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
